// File: rtl/mobo_bus_arb_pkg.sv
// Shared constants for the mobo bus arbiter: requester/device command bits,
// status codes, arbiter state encoding and the default bus word width.
// Every arbiter file imports this package.
package mobo_bus_arb_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 16;

  // Command bits carried on rqN_ctrl / dev_ctrl.
  localparam int unsigned CTRL_READ  = 1;
  localparam int unsigned CTRL_WRITE = 2;

  // Status codes carried on rqN_stat / dev_stat.
  localparam int unsigned STAT_IDLE = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mobo_bus_arb_if.sv
// Bus bundle between two requesters (rq0 = CPU, rq1 = DMA), the arbiter and
// the shared device.
//   master modport: arbiter view (drives dev_* command side, rqN_stat/rdata)
//   slave modport : environment view (drives rqN_ctrl/addr/wdata, dev_stat/rdata)
interface mobo_bus_arb_if
  import mobo_bus_arb_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) ();

  logic [WORD_WIDTH-1:0] rq0_ctrl, rq1_ctrl;
  logic [WORD_WIDTH-1:0] rq0_addr, rq1_addr;
  logic [WORD_WIDTH-1:0] rq0_wdata, rq1_wdata;
  logic [WORD_WIDTH-1:0] rq0_stat, rq1_stat;
  logic [WORD_WIDTH-1:0] rq0_rdata, rq1_rdata;
  logic [WORD_WIDTH-1:0] dev_ctrl, dev_addr, dev_wdata;
  logic [WORD_WIDTH-1:0] dev_stat, dev_rdata;

  modport master (
    input  rq0_ctrl, rq1_ctrl, rq0_addr, rq1_addr, rq0_wdata, rq1_wdata,
    input  dev_stat, dev_rdata,
    output rq0_stat, rq1_stat, rq0_rdata, rq1_rdata,
    output dev_ctrl, dev_addr, dev_wdata
  );

  modport slave (
    output rq0_ctrl, rq1_ctrl, rq0_addr, rq1_addr, rq0_wdata, rq1_wdata,
    output dev_stat, dev_rdata,
    input  rq0_stat, rq1_stat, rq0_rdata, rq1_rdata,
    input  dev_ctrl, dev_addr, dev_wdata
  );

endinterface

// File: rtl/mobo_bus_arb_rr_pick.sv
// Two-way round-robin choice.
//   req0, req1 : requester has a pending command
//   last       : index of the requester granted last
//   valid      : at least one request pending
//   pick       : index of the requester to grant
module mobo_bus_arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = req0 | req1;
    // On contention the one not served last wins; otherwise the lone requester.
    pick  = (req0 && req1) ? ~last : req1;
  end

endmodule

// File: rtl/mobo_bus_arb.sv
// Round-robin arbiter granting one of two requesters (rq0 = CPU, rq1 = DMA)
// access to a single shared device bus. All outputs are registered.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mobo_bus_arb_if.master (requester ports, device ports)
// Parameters: WORD_WIDTH (bus word width), TIMEOUT_CYCLES (busy watchdog).
// Build option: define MOBO_ARB_TIMEOUT_EN to enable the busy watchdog, which
// reports STAT_ERR when the device does not finish within TIMEOUT_CYCLES.
module mobo_bus_arb
  import mobo_bus_arb_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = WORD_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst,
  mobo_bus_arb_if.master bus
);

  localparam logic [WORD_WIDTH-1:0] CtrlRead = WORD_WIDTH'(CTRL_READ);
  localparam logic [WORD_WIDTH-1:0] StIdle   = WORD_WIDTH'(STAT_IDLE);
  localparam logic [WORD_WIDTH-1:0] StDone   = WORD_WIDTH'(STAT_DONE);

  arb_state_e            state_q, state_d;
  logic                  gnt_q, gnt_d;     // requester currently owning the device
  logic                  last_q, last_d;   // requester granted last
  logic [WORD_WIDTH-1:0] dev_ctrl_q, dev_ctrl_d;
  logic [WORD_WIDTH-1:0] dev_addr_q, dev_addr_d;
  logic [WORD_WIDTH-1:0] dev_wdata_q, dev_wdata_d;
  logic [WORD_WIDTH-1:0] stat0_q, stat0_d, stat1_q, stat1_d;
  logic [WORD_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                  pick_valid, pick_idx;
  logic [WORD_WIDTH-1:0] sel_ctrl, sel_addr, sel_wdata, gnt_ctrl;
  logic                  dev_done, timeout_hit;
  logic [WORD_WIDTH-1:0] end_stat;

  mobo_bus_arb_rr_pick u_pick (
    .req0  (|bus.rq0_ctrl),
    .req1  (|bus.rq1_ctrl),
    .last  (last_q),
    .valid (pick_valid),
    .pick  (pick_idx)
  );

`ifdef MOBO_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of completed BUSY cycles; the edge closing the
  // TIMEOUT_CYCLES-th BUSY cycle aborts the transaction.
  always_comb begin
    cnt_d       = (state_q == ARB_BUSY) ? cnt_q + 1'b1 : '0;
    timeout_hit = (state_q == ARB_BUSY) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign end_stat = dev_done ? StDone : WORD_WIDTH'(STAT_ERR);
`else
  assign timeout_hit = 1'b0;
  assign end_stat    = StDone;
`endif

  always_comb begin
    sel_ctrl  = pick_idx ? bus.rq1_ctrl  : bus.rq0_ctrl;
    sel_addr  = pick_idx ? bus.rq1_addr  : bus.rq0_addr;
    sel_wdata = pick_idx ? bus.rq1_wdata : bus.rq0_wdata;
    gnt_ctrl  = gnt_q ? bus.rq1_ctrl : bus.rq0_ctrl;
    dev_done  = (bus.dev_stat == StDone);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    dev_ctrl_d  = dev_ctrl_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    stat0_d     = stat0_q;
    stat1_d     = stat1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d       = pick_idx;
          // Read wins when both command bits are set.
          dev_ctrl_d  = sel_ctrl[0] ? CtrlRead : sel_ctrl;
          dev_addr_d  = sel_addr;
          dev_wdata_d = sel_wdata;
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (dev_done || timeout_hit) begin
          dev_ctrl_d = '0;
          state_d    = ARB_DONE;
          if (gnt_q) begin
            stat1_d = end_stat;
            if (dev_done && dev_ctrl_q[0]) rdata1_d = bus.dev_rdata;
          end else begin
            stat0_d = end_stat;
            if (dev_done && dev_ctrl_q[0]) rdata0_d = bus.dev_rdata;
          end
        end
      end
      ARB_DONE: begin
        if ((gnt_ctrl == '0) && (bus.dev_stat == StIdle)) begin
          if (gnt_q) stat1_d = StIdle;
          else       stat0_d = StIdle;
          last_d  = gnt_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      dev_ctrl_q  <= '0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      stat0_q     <= StIdle;
      stat1_q     <= StIdle;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      dev_ctrl_q  <= dev_ctrl_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      stat0_q     <= stat0_d;
      stat1_q     <= stat1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.dev_ctrl  = dev_ctrl_q;
  assign bus.dev_addr  = dev_addr_q;
  assign bus.dev_wdata = dev_wdata_q;
  assign bus.rq0_stat  = stat0_q;
  assign bus.rq1_stat  = stat1_q;
  assign bus.rq0_rdata = rdata0_q;
  assign bus.rq1_rdata = rdata1_q;

endmodule

// File: tb/tb_mobo_bus_arb.sv
// Self-checking bench for mobo_bus_arb: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_mobo_bus_arb;
  import mobo_bus_arb_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 8;
`ifdef MOBO_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mobo_bus_arb_if #(.WORD_WIDTH(W)) bus ();

  mobo_bus_arb #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] c0, c1, a0, a1, w0, w1, dst, drd;
  assign bus.rq0_ctrl  = c0;
  assign bus.rq1_ctrl  = c1;
  assign bus.rq0_addr  = a0;
  assign bus.rq1_addr  = a1;
  assign bus.rq0_wdata = w0;
  assign bus.rq1_wdata = w1;
  assign bus.dev_stat  = dst;
  assign bus.dev_rdata = drd;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: who owns the device, whether its result has been
  // reported, and the values each visible output should show.
  int           m_owner;
  bit           m_reported;
  int           m_last;
  int           m_busy_cycles;
  logic [W-1:0] m_dctrl, m_daddr, m_dwdata;
  logic [W-1:0] m_stat  [2];
  logic [W-1:0] m_rdata [2];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_reported = 1'b0; m_last = 1; m_busy_cycles = 0;
    m_dctrl = '0; m_daddr = '0; m_dwdata = '0;
    m_stat[0] = '0; m_stat[1] = '0; m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [W-1:0] cc [2];
    int who;
    cc[0] = c0; cc[1] = c1;
    if (m_owner < 0) begin
      if (cc[0] != 0 || cc[1] != 0) begin
        if (cc[0] != 0 && cc[1] != 0) who = 1 - m_last;
        else who = (cc[0] != 0) ? 0 : 1;
        m_owner = who;
        m_dctrl = cc[who][0] ? W'(CTRL_READ) : cc[who];
        m_daddr = (who == 0) ? a0 : a1;
        m_dwdata = (who == 0) ? w0 : w1;
        m_busy_cycles = 0;
      end
    end else if (!m_reported) begin
      m_busy_cycles++;
      if (dst == W'(STAT_DONE)) begin
        if (m_dctrl == W'(CTRL_READ)) m_rdata[m_owner] = drd;
        m_stat[m_owner] = W'(STAT_DONE);
        m_dctrl = '0;
        m_reported = 1'b1;
      end else if (TimeoutEn && m_busy_cycles >= TO) begin
        m_stat[m_owner] = W'(STAT_ERR);
        m_dctrl = '0;
        m_reported = 1'b1;
      end
    end else if (cc[m_owner] == 0 && dst == W'(STAT_IDLE)) begin
      m_stat[m_owner] = W'(STAT_IDLE);
      m_last = m_owner;
      m_owner = -1;
      m_reported = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("dev_ctrl",  bus.dev_ctrl,  m_dctrl);
    check("dev_addr",  bus.dev_addr,  m_daddr);
    check("dev_wdata", bus.dev_wdata, m_dwdata);
    check("rq0_stat",  bus.rq0_stat,  m_stat[0]);
    check("rq1_stat",  bus.rq1_stat,  m_stat[1]);
    check("rq0_rdata", bus.rq0_rdata, m_rdata[0]);
    check("rq1_rdata", bus.rq1_rdata, m_rdata[1]);
  endtask

  // One clock: model predicts, DUT clocks, outputs sampled 1 time unit later.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    c0 = '0; c1 = '0; a0 = '0; a1 = '0; w0 = '0; w1 = '0; dst = '0; drd = '0;
    model_reset();

    // Reset state
    do_reset();
    check("reset_dev_ctrl", bus.dev_ctrl, 16'h0);
    check("reset_rq0_stat", bus.rq0_stat, W'(STAT_IDLE));

    // rq0 read at 0x0010, device finishes after 3 cycles with 0xBEEF
    c0 = W'(CTRL_READ); a0 = 16'h0010;
    cyc();
    check("read_grant_ctrl", bus.dev_ctrl, 16'h1);
    check("read_grant_addr", bus.dev_addr, 16'h0010);
    c0 = '0;  // dropping early must not abort the device transaction
    cyc(); cyc();
    c0 = W'(CTRL_READ);
    dst = W'(STAT_DONE); drd = 16'hBEEF;
    cyc();
    check("read_rdata", bus.rq0_rdata, 16'hBEEF);
    check("read_stat_done", bus.rq0_stat, W'(STAT_DONE));
    check("read_ctrl_cleared", bus.dev_ctrl, 16'h0);
    dst = '0;
    cyc();
    check("read_stat_held", bus.rq0_stat, W'(STAT_DONE));
    c0 = '0;
    cyc();
    check("read_stat_release", bus.rq0_stat, W'(STAT_IDLE));

    // Simultaneous requests alternate starting with rq0 after reset
    do_reset();
    a0 = 16'h0100; a1 = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      c0 = W'(CTRL_READ); c1 = W'(CTRL_READ);
      cyc();
      check("rr_grant_addr", bus.dev_addr, (i % 2 == 0) ? 16'h0100 : 16'h0200);
      dst = W'(STAT_DONE); drd = 16'h5A00 + W'(i);
      cyc();
      c0 = '0; c1 = '0; dst = '0;
      cyc();
    end
    check("rr_rq0_rdata", bus.rq0_rdata, 16'h5A02);
    check("rr_rq1_rdata", bus.rq1_rdata, 16'h5A03);

    // rq1 write while rq0 idle
    c1 = W'(CTRL_WRITE); a1 = 16'h0200; w1 = 16'h1234;
    cyc();
    check("wr_ctrl", bus.dev_ctrl, W'(CTRL_WRITE));
    check("wr_wdata", bus.dev_wdata, 16'h1234);
    check("wr_addr", bus.dev_addr, 16'h0200);
    dst = W'(STAT_DONE); drd = 16'hDEAD;
    cyc();
    check("wr_rq1_rdata_kept", bus.rq1_rdata, 16'h5A03);
    check("wr_rq1_stat", bus.rq1_stat, W'(STAT_DONE));
    check("wr_rq0_stat_idle", bus.rq0_stat, W'(STAT_IDLE));
    c1 = '0; dst = '0;
    cyc();

    // Read+write command collapses to read
    c0 = 16'h3; a0 = 16'h0042;
    cyc();
    check("rw_ctrl_read", bus.dev_ctrl, 16'h1);
    c0 = '0; dst = W'(STAT_DONE); drd = 16'h7777;
    cyc();
    dst = '0;
    cyc();

    // Reset in the middle of a transaction
    c0 = W'(CTRL_READ); a0 = 16'h0100;
    cyc();
    check("mid_busy_ctrl", bus.dev_ctrl, 16'h1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_ctrl", bus.dev_ctrl, 16'h0);
    check("mid_rst_stat0", bus.rq0_stat, W'(STAT_IDLE));
    check("mid_rst_stat1", bus.rq1_stat, W'(STAT_IDLE));
    #1;
    rst = 1'b0;
    c0 = W'(CTRL_READ); c1 = W'(CTRL_READ); a1 = 16'h0200;
    cyc();
    check("post_rst_rq0_first", bus.dev_addr, 16'h0100);
    dst = W'(STAT_DONE);
    cyc();
    c0 = '0; c1 = '0; dst = '0;
    cyc();

    // Device never completes
    c0 = W'(CTRL_READ); a0 = 16'h0300;
    cyc();
    if (TimeoutEn) begin
      for (int i = 0; i < int'(TO) - 1; i++) cyc();
      check("to_not_yet", bus.rq0_stat, W'(STAT_IDLE));
      cyc();
      check("to_stat_err", bus.rq0_stat, W'(STAT_ERR));
      check("to_ctrl_clear", bus.dev_ctrl, 16'h0);
    end else begin
      for (int i = 0; i < 100; i++) cyc();
      check("no_to_still_busy", bus.dev_ctrl, 16'h1);
      check("no_to_stat_idle", bus.rq0_stat, W'(STAT_IDLE));
      dst = W'(STAT_DONE);
      cyc();
    end
    c0 = '0; dst = '0;
    cyc();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) c0 = W'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) c1 = W'($urandom_range(0, 3));
      a0 = W'($urandom); a1 = W'($urandom);
      w0 = W'($urandom); w1 = W'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    dst = W'(STAT_DONE);
        2:       dst = W'(STAT_ERR);
        default: dst = W'(STAT_IDLE);
      endcase
      drd = W'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
